beam_energy_dir: RTL and testbench
==================================

Name: beam_energy_dir

Overview:
- Downstream of the delay-and-sum beamformer, which produces one 16-bit PCM sample per steering angle on each en_pcm strobe.
- Per beam, accumulates the absolute sample magnitude over a fixed frame of PCM samples.
- At frame end, snapshots all accumulators and runs a sequential argmax scan.
- Reports the loudest beam index and its energy with a one-cycle valid pulse.

Parameters:
- NUM_BEAMS, 3, number of beamformer outputs (angles); ≥2.
- SAMPLE_W, 16, width of each beam sample, two's complement signed.
- FRAME_LEN, 32, PCM samples per frame; ≥1.
- ACC_W, 24, accumulator/energy width, unsigned, saturating.
- IDX_W, 2, width of dir_idx; must satisfy 2^IDX_W ≥ NUM_BEAMS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en_pcm  in  1  PCM strobe; one clk wide; beam_in valid in that cycle.
- beam_in  in  NUM_BEAMS*SAMPLE_W  beam samples; beam b occupies bits [b*SAMPLE_W +: SAMPLE_W].
- dir_valid  out  1  one-cycle pulse when dir_idx/dir_energy update.
- dir_idx  out  IDX_W  index of the highest-energy beam of the last completed frame.
- dir_energy  out  ACC_W  energy of that beam.
- overrun  out  1  sticky; set when a frame ends while a scan is still running.

Behaviour:
- Reset (async, active-high): all accumulators, shadows, the sample counter and scan state are 0. dir_valid=0, dir_idx=0, dir_energy=0, overrun=0. FSM enters ACCUM.
- Magnitude: |x| computed at SAMPLE_W+1 bits. |−2^(SAMPLE_W−1)| = 2^(SAMPLE_W−1), with no wrap.
- Accumulation:
  - On each en_pcm, acc[b] <= sat(acc[b] + |x_b|) for all b.
  - sat clamps to 2^ACC_W−1.
  - Sample counter cnt increments 0..FRAME_LEN−1.
- Frame end (en_pcm with cnt==FRAME_LEN−1):
  - shadow[b] <= sat(acc[b] + |x_b|); the final sample is included.
  - acc[b] <= 0 and cnt <= 0; the next frame starts with no gap.
  - FSM goes to SCAN with si=0, best_e=0, best_i=0.
- FSM states:
  - ACCUM: idle scan.
  - SCAN: one beam per cycle. If shadow[si] > best_e (strict), then best_e <= shadow[si] and best_i <= si. si increments. After si==NUM_BEAMS−1 has been processed, go to DONE.
  - DONE: one cycle. dir_idx <= best_i, dir_energy <= best_e, dir_valid=1, then return to ACCUM.
- Latency: if the frame-end strobe is at edge k, dir_valid is high during the cycle after edge k+NUM_BEAMS+1. That is NUM_BEAMS+1 cycles after the strobe, plus the registered output.
- Ties: the lowest index wins, because the compare is strict. All-zero frame gives idx 0, energy 0.
- Accumulation continues during SCAN/DONE. en_pcm is never ignored.
- Frame end while in SCAN or DONE:
  - Shadows are not overwritten and the current scan completes.
  - That frame's result is discarded; accumulators still clear.
  - overrun <= 1. It is cleared only by reset.
  - Required system rate is en_pcm spacing × FRAME_LEN > NUM_BEAMS+1 clocks.
- dir_idx and dir_energy hold between updates.
- Reset mid-frame or mid-scan: partial data is discarded and no dir_valid is emitted.

Decomposition:
- Shared package holds:
  - FSM state enum {ACCUM, SCAN, DONE};
  - default SAMPLE_W/ACC_W constants;
  - the sat-add width rule.
- One sub-module, abs_sat_acc: per-beam |x|, saturating accumulate, clear-on-frame-end and shadow capture. Instantiate it NUM_BEAMS times via generate.

Test Plan:
- NUM_BEAMS=3, FRAME_LEN=4, en_pcm every 8 clk; beams {10, 100, 10} constant → dir_idx=1, dir_energy=400, dir_valid exactly one cycle, NUM_BEAMS+1 cycles after the 4th strobe.
- Beam2 = −32768, others = 1000, 4 samples → dir_idx=2, dir_energy=131072. Checks negative full-scale magnitude.
- All beams = −5 → tie; dir_idx=0, dir_energy=20. Next frame all 0 → dir_idx=0, dir_energy=0.
- ACC_W=16, beam0=32767 for 4 samples → dir_energy=65535 (saturated), dir_idx=0.
- FRAME_LEN=1, en_pcm every clk → overrun=1 after the 2nd strobe. The first scan result is still delivered and dir_valid never overlaps a scan restart.
- Reset asserted mid-frame (cnt=2) and again mid-SCAN → outputs 0 immediately (async), no dir_valid. The next full frame reports correctly.

Source files
------------

// File: rtl/beam_energy_dir_pkg.sv
// Shared types and width rules for the beam energy / direction-of-arrival block.
package beam_energy_dir_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } scan_state_e;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_ACC_W    = 24;

  // An ACC_W accumulator plus a (sample_w+1)-bit magnitude never overflows this width.
  function automatic int sum_w(input int acc_w, input int sample_w);
    return ((acc_w > sample_w + 1) ? acc_w : sample_w + 1) + 1;
  endfunction

endpackage

// File: rtl/beam_energy_dir_if.sv
// PCM sample bus from the beamformer and the direction result it produces.
interface beam_energy_dir_if #(
  parameter int NUM_BEAMS = 3,
  parameter int SAMPLE_W  = beam_energy_dir_pkg::DEF_SAMPLE_W,
  parameter int ACC_W     = beam_energy_dir_pkg::DEF_ACC_W,
  parameter int IDX_W     = 2
);
  logic                          en_pcm;
  logic [NUM_BEAMS*SAMPLE_W-1:0] beam_in;
  logic                          dir_valid;
  logic [IDX_W-1:0]              dir_idx;
  logic [ACC_W-1:0]              dir_energy;
  logic                          overrun;

  modport master (output en_pcm, beam_in, input dir_valid, dir_idx, dir_energy, overrun);
  modport slave  (input en_pcm, beam_in, output dir_valid, dir_idx, dir_energy, overrun);
endinterface

// File: rtl/abs_sat_acc.sv
// One beam lane: |x|, saturating accumulate, clear at frame end and shadow capture.
module abs_sat_acc
  import beam_energy_dir_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic                frame_end,
  input  logic                capture,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [ACC_W-1:0]    shadow
);
  localparam int SUM_W = sum_w(ACC_W, SAMPLE_W);
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [SAMPLE_W:0]  ext;
  logic [SAMPLE_W:0]  mag;
  logic [SUM_W-1:0]   sum;
  logic [ACC_W-1:0]   sat_sum;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   shadow_q, shadow_d;

  // NOTE: every signal assigned here gets a value on all paths first, so no latch is inferred.
  always_comb begin
    ext      = {sample[SAMPLE_W-1], sample};
    // One extra bit keeps |-2^(SAMPLE_W-1)| from wrapping back to negative.
    mag      = ext[SAMPLE_W] ? (~ext + 1'b1) : ext;
    sum      = SUM_W'(acc_q) + SUM_W'(mag);
    sat_sum  = (sum > ACC_MAX) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    acc_d    = acc_q;
    shadow_d = shadow_q;
    if (sample_en) begin
      acc_d = frame_end ? '0 : sat_sum;
    end
    if (capture) begin
      shadow_d = sat_sum;
    end
  end

  // NOTE: state updates use non-blocking assignments so all lanes sample the same old values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      shadow_q <= '0;
    end else begin
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
    end
  end

  assign shadow = shadow_q;

endmodule

// File: rtl/beam_energy_dir.sv
// Per-frame beam energy accumulation followed by a sequential argmax scan that
// reports the loudest beam and its energy with a one-cycle valid pulse.
module beam_energy_dir
  import beam_energy_dir_pkg::*;
#(
  parameter int NUM_BEAMS = 3,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int FRAME_LEN = 32,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int IDX_W     = 2
) (
  input logic              clk,
  input logic              reset,
  beam_energy_dir_if.slave bus
);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] SI_LAST  = IDX_W'(NUM_BEAMS - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] si_q, si_d;
  logic [IDX_W-1:0] best_i_q, best_i_d;
  logic [IDX_W-1:0] dir_idx_q, dir_idx_d;
  logic [ACC_W-1:0] best_e_q, best_e_d;
  logic [ACC_W-1:0] dir_energy_q, dir_energy_d;
  logic [ACC_W-1:0] cur_e;
  logic             dir_valid_q, dir_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_end;
  logic             capture;
  logic [ACC_W-1:0] shadow [NUM_BEAMS];

  assign frame_end = bus.en_pcm && (cnt_q == CNT_LAST);
  // A frame ending mid-scan must not disturb the shadows being scanned.
  assign capture   = frame_end && (state_q == ACCUM);

  for (genvar b = 0; b < NUM_BEAMS; b++) begin : g_beam
    abs_sat_acc #(
      .SAMPLE_W(SAMPLE_W),
      .ACC_W   (ACC_W)
    ) u_acc (
      .clk      (clk),
      .reset    (reset),
      .sample_en(bus.en_pcm),
      .frame_end(frame_end),
      .capture  (capture),
      .sample   (bus.beam_in[b*SAMPLE_W +: SAMPLE_W]),
      .shadow   (shadow[b])
    );
  end

  always_comb begin
    cur_e = '0;
    for (int b = 0; b < NUM_BEAMS; b++) begin
      if (si_q == IDX_W'(b)) cur_e = shadow[b];
    end

    cnt_d = cnt_q;
    if (bus.en_pcm) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    state_d      = state_q;
    si_d         = si_q;
    best_i_d     = best_i_q;
    best_e_d     = best_e_q;
    dir_valid_d  = 1'b0;
    dir_idx_d    = dir_idx_q;
    dir_energy_d = dir_energy_q;
    overrun_d    = overrun_q;

    if (frame_end && (state_q != ACCUM)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ACCUM: begin
        if (frame_end) begin
          state_d  = SCAN;
          si_d     = '0;
          best_i_d = '0;
          best_e_d = '0;
        end
      end
      SCAN: begin
        // Strict compare: on a tie the earlier (lower) index is kept.
        if (cur_e > best_e_q) begin
          best_e_d = cur_e;
          best_i_d = si_q;
        end
        if (si_q == SI_LAST) begin
          state_d = DONE;
        end else begin
          si_d = si_q + 1'b1;
        end
      end
      DONE: begin
        dir_valid_d  = 1'b1;
        dir_idx_d    = best_i_q;
        dir_energy_d = best_e_q;
        state_d      = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ACCUM;
      cnt_q        <= '0;
      si_q         <= '0;
      best_i_q     <= '0;
      best_e_q     <= '0;
      dir_valid_q  <= 1'b0;
      dir_idx_q    <= '0;
      dir_energy_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      si_q         <= si_d;
      best_i_q     <= best_i_d;
      best_e_q     <= best_e_d;
      dir_valid_q  <= dir_valid_d;
      dir_idx_q    <= dir_idx_d;
      dir_energy_q <= dir_energy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dir_valid  = dir_valid_q;
  assign bus.dir_idx    = dir_idx_q;
  assign bus.dir_energy = dir_energy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_beam_energy_dir.sv
// Randomized bench for beam_energy_dir: three instances (24-bit and 16-bit
// energy with 4-sample frames, and 1-sample frames) checked against a frame-level model.
module tb_beam_energy_dir;

  localparam int NB = 3;
  localparam int SW = 16;
  localparam int FL = 4;
  localparam int IW = 2;
  localparam int NBURST = 10;

  typedef struct {
    int     c;
    int     idx;
    longint e;
  } pulse_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            en_pcm;
  logic            en_f;
  logic [NB*SW-1:0] beam_in;
  int              cyc = 0;
  int              errors = 0;
  int              checks = 0;

  logic signed [SW-1:0] frame [FL][NB];
  logic signed [SW-1:0] burst [NBURST][NB];
  pulse_t qa[$], qs[$], qf[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beam_energy_dir_if #(.NUM_BEAMS(NB), .SAMPLE_W(SW), .ACC_W(24), .IDX_W(IW)) bus_a ();
  beam_energy_dir_if #(.NUM_BEAMS(NB), .SAMPLE_W(SW), .ACC_W(16), .IDX_W(IW)) bus_s ();
  beam_energy_dir_if #(.NUM_BEAMS(NB), .SAMPLE_W(SW), .ACC_W(24), .IDX_W(IW)) bus_f ();

  assign bus_a.en_pcm  = en_pcm;
  assign bus_a.beam_in = beam_in;
  assign bus_s.en_pcm  = en_pcm;
  assign bus_s.beam_in = beam_in;
  assign bus_f.en_pcm  = en_f;
  assign bus_f.beam_in = beam_in;

  beam_energy_dir #(.NUM_BEAMS(NB), .SAMPLE_W(SW), .FRAME_LEN(FL), .ACC_W(24), .IDX_W(IW))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  beam_energy_dir #(.NUM_BEAMS(NB), .SAMPLE_W(SW), .FRAME_LEN(FL), .ACC_W(16), .IDX_W(IW))
    dut_s (.clk(clk), .reset(reset), .bus(bus_s.slave));
  beam_energy_dir #(.NUM_BEAMS(NB), .SAMPLE_W(SW), .FRAME_LEN(1), .ACC_W(24), .IDX_W(IW))
    dut_f (.clk(clk), .reset(reset), .bus(bus_f.slave));

  always @(negedge clk) begin
    if (bus_a.dir_valid === 1'b1) qa.push_back('{c: cyc, idx: int'(bus_a.dir_idx), e: longint'(bus_a.dir_energy)});
    if (bus_s.dir_valid === 1'b1) qs.push_back('{c: cyc, idx: int'(bus_s.dir_idx), e: longint'(bus_s.dir_energy)});
    if (bus_f.dir_valid === 1'b1) qf.push_back('{c: cyc, idx: int'(bus_f.dir_idx), e: longint'(bus_f.dir_energy)});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint mag(input logic signed [SW-1:0] x);
    return (x < 0) ? -longint'(x) : longint'(x);
  endfunction

  // Loudest beam: find the peak value, then the first beam holding it.
  task automatic pick_best(input longint en [NB], output int idx, output longint mx);
    mx = 0;
    for (int b = 0; b < NB; b++) if (en[b] > mx) mx = en[b];
    idx = 0;
    for (int b = NB - 1; b >= 0; b--) if (en[b] == mx) idx = b;
  endtask

  task automatic model_frame(input int accw, output int idx, output longint e);
    longint en [NB];
    longint lim;
    lim = (longint'(1) << accw) - 1;
    for (int b = 0; b < NB; b++) begin
      en[b] = 0;
      for (int s = 0; s < FL; s++) en[b] += mag(frame[s][b]);
      if (en[b] > lim) en[b] = lim;
    end
    pick_best(en, idx, e);
  endtask

  task automatic set_const(input int v0, input int v1, input int v2);
    for (int s = 0; s < FL; s++) begin
      frame[s][0] = SW'(v0);
      frame[s][1] = SW'(v1);
      frame[s][2] = SW'(v2);
    end
  endtask

  function automatic logic [SW-1:0] rnd_sample();
    logic [SW-1:0] picks [5];
    picks = '{16'h8000, 16'h7fff, 16'h0000, 16'hffff, 16'h0005};
    if ($urandom_range(0, 2) == 0) return picks[$urandom_range(0, 4)];
    return SW'($urandom);
  endfunction

  // Strobes n frame samples 8 clocks apart; k is the edge that sampled the last strobe.
  task automatic send_samples(input int n, input int tail, output int k);
    k = 0;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) beam_in[b*SW +: SW] = frame[s][b];
      en_pcm = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      en_pcm = 1'b0;
      repeat ((s == n - 1) ? tail : 6) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag);
    int k, ia, is;
    longint ea, es;
    send_samples(FL, 10, k);
    model_frame(24, ia, ea);
    model_frame(16, is, es);
    check({tag, " pulses"}, qa.size(), 1);
    if (qa.size() > 0) begin
      check({tag, " latency"}, qa[0].c, k + NB + 1);
      check({tag, " idx"}, qa[0].idx, ia);
      check({tag, " energy"}, qa[0].e, ea);
    end
    check({tag, " sat pulses"}, qs.size(), 1);
    if (qs.size() > 0) begin
      check({tag, " sat idx"}, qs[0].idx, is);
      check({tag, " sat energy"}, qs[0].e, es);
    end
    check({tag, " overrun"}, bus_a.overrun, 0);
    qa.delete();
    qs.delete();
  endtask

  initial begin
    int k, last, nexp;
    longint en [NB];
    pulse_t fexp[$];
    pulse_t p;

    reset   = 1'b1;
    en_pcm  = 1'b0;
    en_f    = 1'b0;
    beam_in = '0;
    repeat (3) @(negedge clk);
    check("rst valid", bus_a.dir_valid, 0);
    check("rst idx", bus_a.dir_idx, 0);
    check("rst energy", bus_a.dir_energy, 0);
    check("rst overrun", bus_a.overrun, 0);
    check("rst sat energy", bus_s.dir_energy, 0);
    check("rst f overrun", bus_f.overrun, 0);
    reset = 1'b0;

    set_const(10, 100, 10);       run_frame("basic");
    set_const(1000, 1000, -32768); run_frame("negfs");
    set_const(-5, -5, -5);        run_frame("tie");
    set_const(0, 0, 0);           run_frame("zero");
    set_const(32767, 0, 0);       run_frame("sat");

    for (int f = 0; f < 12; f++) begin
      for (int s = 0; s < FL; s++)
        for (int b = 0; b < NB; b++) frame[s][b] = rnd_sample();
      run_frame($sformatf("rnd%0d", f));
    end

    // Reset mid-frame after two samples, with a nonzero result on the outputs.
    set_const(1, 2, 300);  run_frame("pre rst");
    set_const(900, 900, 900);
    send_samples(2, 3, k);
    #2 reset = 1'b1;
    #1;
    check("rst mid-frame idx", bus_a.dir_idx, 0);
    check("rst mid-frame energy", bus_a.dir_energy, 0);
    @(negedge clk) reset = 1'b0;
    set_const(4, 3, 2);    run_frame("post rst frame");

    // Reset while the argmax scan is in progress.
    set_const(7, 70, 700);
    send_samples(FL, 1, k);
    #2 reset = 1'b1;
    #1;
    check("rst mid-scan idx", bus_a.dir_idx, 0);
    check("rst mid-scan energy", bus_a.dir_energy, 0);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst mid-scan pulses", qa.size(), 0);
    qa.delete();
    qs.delete();
    set_const(50, 20, 60); run_frame("post scan rst");

    // One-sample frames strobed every clock: frames arriving mid-scan are dropped.
    for (int t = 0; t < NBURST; t++) begin
      @(negedge clk);
      if (t == 1) check("burst overrun after 1st", bus_f.overrun, 0);
      if (t == 2) check("burst overrun after 2nd", bus_f.overrun, 1);
      for (int b = 0; b < NB; b++) begin
        burst[t][b] = rnd_sample();
        beam_in[b*SW +: SW] = burst[t][b];
      end
      en_f = 1'b1;
      k = cyc + 1;
      if (t == 0) last = k - 1000;
      if (k >= last + NB + 2) begin
        last = k;
        for (int b = 0; b < NB; b++) en[b] = mag(burst[t][b]);
        p.c = k + NB + 1;
        pick_best(en, p.idx, p.e);
        fexp.push_back(p);
      end
    end
    @(negedge clk) en_f = 1'b0;
    repeat (12) @(negedge clk);
    nexp = fexp.size();
    check("burst pulses", qf.size(), nexp);
    for (int i = 0; i < nexp && i < qf.size(); i++) begin
      check($sformatf("burst%0d cycle", i), qf[i].c, fexp[i].c);
      check($sformatf("burst%0d idx", i), qf[i].idx, fexp[i].idx);
      check($sformatf("burst%0d energy", i), qf[i].e, fexp[i].e);
    end
    check("burst overrun sticky", bus_f.overrun, 1);
    check("main overrun clear", bus_a.overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
